// File: rtl/stream_mux_n_if.sv
// Handshake bundle between N producers, the stream mux and its single consumer.
// The master side drives the producer inputs and the consumer ready signal.
interface stream_mux_n_if #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = 2
);
  logic            mode;
  logic [SW-1:0]   sel;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_ch;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/stream_mux_n.sv
// N-channel registered stream multiplexer with fixed-select or round-robin
// arbitration and a one-entry output register that supports full throughput.
module stream_mux_n #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = 2
) (
  input logic           clk,
  input logic           rst,
  stream_mux_n_if.slave bus
);

  logic [N-1:0]  grant;
  logic [SW-1:0] grant_idx;
  logic          grant_any;
  logic [SW-1:0] cand;
  logic          can_load;
  logic          load;
  logic [W-1:0]  load_data;

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_ch_q,    out_ch_d;
  logic [SW-1:0] ptr_q,       ptr_d;

  assign can_load = !out_valid_q || bus.out_ready;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    if (!bus.mode) begin
      // An out-of-range sel never matches any channel, so nothing is granted.
      for (int unsigned k = 0; k < N; k++) begin
        if (bus.sel == SW'(k) && bus.in_valid[k]) begin
          grant[k]  = 1'b1;
          grant_idx = SW'(k);
          grant_any = 1'b1;
        end
      end
    end else begin
      // Search starts just past the last winner and wraps modulo N.
      for (int unsigned i = 1; i <= N; i++) begin
        cand = SW'((32'(ptr_q) + i) % N);
        if (!grant_any && bus.in_valid[cand]) begin
          grant[cand] = 1'b1;
          grant_idx   = cand;
          grant_any   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    load_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (grant[k]) load_data = bus.in_data[k*W +: W];
    end
  end

  assign load = grant_any && can_load && !rst;

  always_comb begin
    bus.in_ready = '0;
    if (can_load && !rst) bus.in_ready = grant;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = load_data;
      out_ch_d    = grant_idx;
      if (bus.mode) ptr_d = grant_idx;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= SW'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: a 4-channel and a 3-channel instance share stimulus
// and are compared each cycle against a queue-free behavioural model.
module tb_stream_mux_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] data;
  logic [3:0]  valid;
  logic        oready;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  stream_mux_n_if #(.N(4), .W(8), .SW(2)) if4 ();
  stream_mux_n_if #(.N(3), .W(8), .SW(2)) if3 ();

  assign if4.mode      = mode;
  assign if4.sel       = sel;
  assign if4.in_data   = data;
  assign if4.in_valid  = valid;
  assign if4.out_ready = oready;
  assign if3.mode      = mode;
  assign if3.sel       = sel;
  assign if3.in_data   = data[23:0];
  assign if3.in_valid  = valid[2:0];
  assign if3.out_ready = oready;

  stream_mux_n #(.N(4), .W(8), .SW(2)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));
  stream_mux_n #(.N(3), .W(8), .SW(2)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));

  // Model state: index 0 is the 4-channel instance, index 1 the 3-channel one.
  int nch[2] = '{4, 3};
  bit m_ov[2];
  int m_od[2];
  int m_och[2];
  int m_ptr[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int grant_of(int n, int ptr, bit md, int s, logic [3:0] v);
    if (!md) return (s < n && v[s]) ? s : -1;
    for (int i = 1; i <= n; i++) begin
      int c;
      c = (ptr + i) % n;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic int exp_ready(int d);
    int g;
    if (rst) return 0;
    g = grant_of(nch[d], m_ptr[d], mode, int'(sel), valid);
    if (g >= 0 && (!m_ov[d] || oready)) return 1 << g;
    return 0;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_ov[d] = 1'b0; m_od[d] = 0; m_och[d] = 0; m_ptr[d] = nch[d] - 1;
      end else begin
        int g;
        g = grant_of(nch[d], m_ptr[d], mode, int'(sel), valid);
        if (g >= 0 && (!m_ov[d] || oready)) begin
          m_ov[d]  = 1'b1;
          m_od[d]  = (data >> (8 * g)) & 32'hFF;
          m_och[d] = g;
          if (mode) m_ptr[d] = g;
        end else if (m_ov[d] && oready) begin
          m_ov[d] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("u4_out_valid", 32'(if4.out_valid), 32'(m_ov[0]));
      chk("u4_out_data",  32'(if4.out_data),  m_od[0]);
      chk("u4_out_ch",    32'(if4.out_ch),    m_och[0]);
      chk("u4_in_ready",  32'(if4.in_ready),  exp_ready(0));
      chk("u3_out_valid", 32'(if3.out_valid), 32'(m_ov[1]));
      chk("u3_out_data",  32'(if3.out_data),  m_od[1]);
      chk("u3_out_ch",    32'(if3.out_ch),    m_och[1]);
      chk("u3_in_ready",  32'(if3.in_ready),  exp_ready(1));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rr_a[6];
    int rr_b[4];
    rr_a = '{0, 1, 2, 3, 0, 1};
    rr_b = '{3, 1, 3, 1};

    rst = 1'b1; mode = 1'b1; sel = 2'd0; data = '0; valid = 4'b1111; oready = 1'b1;
    step(); step();
    cmp_en = 1'b1;
    chk("rst_out_valid", 32'(if4.out_valid), 0);
    chk("rst_out_data",  32'(if4.out_data),  0);
    chk("rst_out_ch",    32'(if4.out_ch),    0);
    chk("rst_in_ready",  32'(if4.in_ready),  0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready4", 32'(if4.in_ready), 32'h1);
    chk("post_rst_ready3", 32'(if3.in_ready), 32'h1);

    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_all_ch", 32'(if4.out_ch), rr_a[i]);
      chk("rr_all_valid", 32'(if4.out_valid), 1);
    end
    valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_1010_ch", 32'(if4.out_ch), rr_b[i]);
    end

    mode = 1'b0; sel = 2'd2; data = 32'h00A5_0000; valid = 4'b0100;
    step();
    chk("fix_data", 32'(if4.out_data), 32'hA5);
    chk("fix_ch",   32'(if4.out_ch),   2);
    chk("fix_valid", 32'(if4.out_valid), 1);
    sel = 2'd3;
    step();
    chk("fix_drain_valid", 32'(if4.out_valid), 0);

    sel = 2'd0; valid = 4'b0001; data = 32'h0000_003C;
    step();
    chk("bp_load", 32'(if4.out_data), 32'h3C);
    oready = 1'b0; data = 32'h0000_0077;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_data",  32'(if4.out_data),  32'h3C);
      chk("bp_hold_valid", 32'(if4.out_valid), 1);
      chk("bp_ready_low",  32'(if4.in_ready),  0);
    end
    oready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(if4.in_ready), 32'h1);
    step();
    chk("bp_next_data",  32'(if4.out_data),  32'h77);
    chk("bp_next_valid", 32'(if4.out_valid), 1);

    mode = 1'b1; valid = 4'b0100;
    step();
    chk("n3_ch2", 32'(if3.out_ch), 2);
    valid = 4'b0011;
    #1;
    chk("n3_wrap_ready", 32'(if3.in_ready), 32'h1);
    step();
    chk("n3_wrap_ch", 32'(if3.out_ch), 0);
    mode = 1'b0; sel = 2'd3; valid = 4'b0111;
    #1;
    chk("n3_oor_ready", 32'(if3.in_ready), 0);
    step();
    chk("n3_oor_valid", 32'(if3.out_valid), 0);

    mode = 1'b1; valid = 4'b1111; oready = 1'b0;
    step();
    chk("stall_load", 32'(if4.out_valid), 1);
    step();
    chk("stall_hold", 32'(if4.out_valid), 1);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 32'(if4.out_valid), 0);
    rst = 1'b0; oready = 1'b1;
    step();
    chk("mid_rst_ch4", 32'(if4.out_ch), 0);
    chk("mid_rst_ch3", 32'(if3.out_ch), 0);

    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      sel    = 2'($urandom_range(0, 3));
      data   = $urandom;
      valid  = 4'($urandom_range(0, 15));
      oready = ($urandom_range(0, 3) != 0);
      step();
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
